comp_mul_sequencer: RTL and testbench
=====================================

// Module: comp_mul_sequencer
// PURPOSE
//  Controller for the shared 2-bit compare/multiply datapath (operands a,b; PB0 selects function).
//  Debounces the board push-button into a function-mode toggle, drives operands from switches (manual)
//  or steps all 16 operand pairs (auto scan), waits for the datapath to settle and latches its 4-bit
//  result onto the LEDs. Sits between board I/O and the datapath instance.
// PARAMETERS
//  DB_CYCLES     16  consecutive stable samples required to accept a new button level
//  SETTLE_CYCLES 2   cycles operands are held before dp_out is captured (>=1)
//  HOLD_CYCLES   8   cycles a captured result is shown before the next auto-scan step (>=1)
// PORTS
//  clk      in  1  system clock, all state on rising edge
//  rst_n    in  1  asynchronous, active-low reset
//  btn_in   in  1  raw push-button, asynchronous, bouncy
//  auto_en  in  1  1 = auto scan of operand pairs, 0 = manual switches
//  sw_a     in  2  manual operand a
//  sw_b     in  2  manual operand b
//  dp_out   in  4  datapath result
//  dp_a     out 2  operand a to datapath (registered)
//  dp_b     out 2  operand b to datapath (registered)
//  dp_pb0   out 1  function select to datapath (= mode, registered)
//  led      out 4  latched result
//  busy     out 1  1 in APPLY/SETTLE/CAPTURE
//  done     out 1  1-cycle pulse in the cycle led is updated
// BEHAVIOUR
//  Reset: state IDLE; dp_a,dp_b,dp_pb0,led,busy,done,mode,scan_idx,counters = 0; pending = 1.
//  Button: 2-FF synchroniser -> counter; btn_stable takes the synced level after DB_CYCLES
//   consecutive equal samples (counter clears on any mismatch). Rising edge of btn_stable toggles mode.
//   Falling edge and bounces shorter than DB_CYCLES: no effect.
//  FSM IDLE -> APPLY -> SETTLE -> CAPTURE -> HOLD:
//   IDLE: go APPLY if pending, or auto_en=1, or {mode,sw_a,sw_b} != last_applied (manual).
//   APPLY (1 cycle): dp_pb0<=mode; dp_a/dp_b <= sw_a/sw_b (manual) or scan_idx[3:2]/[1:0] (auto);
//    last_applied<={mode,sw_a,sw_b}; pending<=0.
//   SETTLE: exactly SETTLE_CYCLES cycles, then CAPTURE.
//   CAPTURE (1 cycle): led<=dp_out; done=1; then HOLD if auto_en=1, else IDLE.
//   HOLD: HOLD_CYCLES cycles; then scan_idx<=scan_idx+1 (4-bit, 15 wraps to 0), go APPLY.
//    If auto_en=0 during HOLD: go IDLE at once, scan_idx unchanged.
//  Manual latency: input change seen in IDLE at cycle t -> dp_* valid t+1 -> led/done at t+2+SETTLE_CYCLES.
//  Mode toggle while busy or in HOLD: abort to APPLY next cycle with new mode, same operands;
//   led keeps old value, no done. Switch change while busy: ignored until IDLE (then detected).
//  auto_en falling during APPLY/SETTLE: sequence completes with auto operands, then IDLE.
//  Toggle and CAPTURE in same cycle: capture completes (led, done), then APPLY with new mode.
//  rst_n low mid-sequence: immediate return to reset values; no done pulse.
// TESTING (bench model: mode 0 -> dp_out=a*b; mode 1 -> dp_out={1'b0,a>b,a==b,a<b})
//  Reset release, sw_a=01 sw_b=11, auto_en=0 -> first capture led=0011, done once, then IDLE.
//  sw_a=11 sw_b=11 -> led=1001 exactly 2+SETTLE_CYCLES cycles after change; busy high APPLY..CAPTURE.
//  btn bounces 5 cycles then held 40 cycles -> mode toggles once; sw 11/01 re-captured led=0100.
//  Glitch of DB_CYCLES-1 cycles on btn_in -> no mode change, no new capture.
//  auto_en=1, mode 0 -> 16 done pulses HOLD_CYCLES+SETTLE_CYCLES+2 apart, led=a*b for idx 0..15,
//   idx wraps to 0 (led=0000); button press mid-SETTLE -> restart step, no done for aborted step.
//  rst_n asserted in SETTLE -> all outputs 0 immediately; after release pending capture occurs.

Source files
------------

// File: rtl/comp_mul_sequencer_if.sv
// comp_mul_sequencer_if
//   Board-side and datapath-side signals of the compare/multiply sequencer.
//   slave  : the sequencer (consumes button/switches/dp_out, drives operands and LEDs)
//   master : the surroundings (board I/O plus the datapath instance)
//   btn_in  raw push-button          auto_en  1 = auto scan, 0 = manual switches
//   sw_a    manual operand a         sw_b     manual operand b
//   dp_out  datapath result          dp_a/dp_b/dp_pb0  operands and function select
//   led     latched result           busy     sequence in flight   done  capture pulse
interface comp_mul_sequencer_if;
  logic       btn_in;
  logic       auto_en;
  logic [1:0] sw_a;
  logic [1:0] sw_b;
  logic [3:0] dp_out;
  logic [1:0] dp_a;
  logic [1:0] dp_b;
  logic       dp_pb0;
  logic [3:0] led;
  logic       busy;
  logic       done;

  modport slave (
    input  btn_in, auto_en, sw_a, sw_b, dp_out,
    output dp_a, dp_b, dp_pb0, led, busy, done
  );

  modport master (
    output btn_in, auto_en, sw_a, sw_b, dp_out,
    input  dp_a, dp_b, dp_pb0, led, busy, done
  );
endinterface

// File: rtl/comp_mul_sequencer.sv
// comp_mul_sequencer
//   Controller for a shared 2-bit compare/multiply datapath. A debounced button
//   press toggles the function mode; operands come from the switches (manual)
//   or from a 4-bit scan index (auto). Each sequence applies the operands,
//   waits SETTLE_CYCLES, latches dp_out onto the LEDs and pulses done.
// Ports
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    comp_mul_sequencer_if.slave (button, switches, datapath, LEDs, status)
module comp_mul_sequencer #(
  parameter int DB_CYCLES     = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  comp_mul_sequencer_if.slave   bus
);

  localparam int DB_W    = $clog2(DB_CYCLES + 1);
  localparam int CNT_MAX = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_APPLY   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  // Button conditioning
  logic            sync1_r;
  logic            sync2_r;
  logic [DB_W-1:0] db_cnt_r;
  logic            btn_stable_r;
  logic            toggle_r;
  logic            mode_r;

  // Sequencer state
  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       scan_idx_r;
  logic [3:0]       scan_sel_s;
  logic             scan_inc_s;
  logic             capture_s;
  logic             change_s;
  logic [4:0]       last_applied_r;
  logic             pending_r;

  // Registered outputs
  logic [1:0] dp_a_r;
  logic [1:0] dp_b_r;
  logic       dp_pb0_r;
  logic [3:0] led_r;
  logic       busy_r;
  logic       done_r;

  // Synchronise and debounce the button; a debounced rising edge flips the mode
  // and raises toggle_r for one cycle, in which mode_r already holds the new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r      <= 1'b0;
      sync2_r      <= 1'b0;
      db_cnt_r     <= '0;
      btn_stable_r <= 1'b0;
      toggle_r     <= 1'b0;
      mode_r       <= 1'b0;
    end else begin
      sync1_r  <= bus.btn_in;
      sync2_r  <= sync1_r;
      toggle_r <= 1'b0;
      if (sync2_r == btn_stable_r) begin
        db_cnt_r <= '0;
      end else if (db_cnt_r == DB_W'(DB_CYCLES - 1)) begin
        db_cnt_r     <= '0;
        btn_stable_r <= sync2_r;
        if (sync2_r) begin
          toggle_r <= 1'b1;
          mode_r   <= ~mode_r;
        end
      end else begin
        db_cnt_r <= db_cnt_r + {{(DB_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Next-state logic; a mode toggle in any active state restarts at APPLY.
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    scan_inc_s  = 1'b0;
    change_s    = ({mode_r, bus.sw_a, bus.sw_b} != last_applied_r);
    case (state_r)
      ST_IDLE: begin
        if (pending_r || bus.auto_en || change_s || toggle_r) begin
          state_nxt_s = ST_APPLY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_APPLY: begin
        if (toggle_r) begin
          state_nxt_s = ST_APPLY;
        end else begin
          state_nxt_s = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (toggle_r) begin
          state_nxt_s = ST_APPLY;
        end else if (cnt_r == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_nxt_s = ST_CAPTURE;
          capture_s   = 1'b1;
        end else begin
          state_nxt_s = ST_SETTLE;
        end
      end
      ST_CAPTURE: begin
        if (toggle_r) begin
          state_nxt_s = ST_APPLY;
        end else if (bus.auto_en) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (toggle_r) begin
          state_nxt_s = ST_APPLY;
        end else if (!bus.auto_en) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == CNT_W'(HOLD_CYCLES - 1)) begin
          state_nxt_s = ST_APPLY;
          scan_inc_s  = 1'b1;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    if (scan_inc_s) begin
      scan_sel_s = scan_idx_r + 4'd1;
    end else begin
      scan_sel_s = scan_idx_r;
    end
  end

  // State register and SETTLE/HOLD cycle counter (cleared on every state entry).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_nxt_s == state_r) &&
          ((state_r == ST_SETTLE) || (state_r == ST_HOLD))) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= '0;
      end
    end
  end

  // Operand load on APPLY entry, result capture on CAPTURE entry, status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_a_r         <= 2'b00;
      dp_b_r         <= 2'b00;
      dp_pb0_r       <= 1'b0;
      led_r          <= 4'b0000;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      scan_idx_r     <= 4'd0;
      last_applied_r <= 5'd0;
      pending_r      <= 1'b1;
    end else begin
      done_r <= capture_s;
      busy_r <= (state_nxt_s == ST_APPLY) || (state_nxt_s == ST_SETTLE) ||
                (state_nxt_s == ST_CAPTURE);
      if (capture_s) begin
        led_r <= bus.dp_out;
      end
      if (scan_inc_s) begin
        scan_idx_r <= scan_sel_s;
      end
      if (state_nxt_s == ST_APPLY) begin
        dp_pb0_r       <= mode_r;
        last_applied_r <= {mode_r, bus.sw_a, bus.sw_b};
        pending_r      <= 1'b0;
        if (bus.auto_en) begin
          dp_a_r <= scan_sel_s[3:2];
          dp_b_r <= scan_sel_s[1:0];
        end else begin
          dp_a_r <= bus.sw_a;
          dp_b_r <= bus.sw_b;
        end
      end
    end
  end

  assign bus.dp_a   = dp_a_r;
  assign bus.dp_b   = dp_b_r;
  assign bus.dp_pb0 = dp_pb0_r;
  assign bus.led    = led_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;

endmodule

// File: tb/tb_comp_mul_sequencer.sv
// tb_comp_mul_sequencer
//   Self-checking bench for comp_mul_sequencer. Models the datapath
//   (mode 0: a*b, mode 1: {0,a>b,a==b,a<b}), drives the board inputs and
//   compares LEDs, status and timing against values computed here.
module tb_comp_mul_sequencer;

  localparam int DB  = 16;
  localparam int ST  = 2;
  localparam int HD  = 8;
  localparam int LAT = 2 + ST;
  localparam int PER = HD + ST + 2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;
  logic cur_mode;
  logic [1:0] cur_a;
  logic [1:0] cur_b;

  comp_mul_sequencer_if bus();

  comp_mul_sequencer #(
    .DB_CYCLES(DB), .SETTLE_CYCLES(ST), .HOLD_CYCLES(HD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [3:0] ref_led(input logic [1:0] a, input logic [1:0] b,
                                         input logic m);
    logic [3:0] r;
    if (m) r = {1'b0, a > b, a == b, a < b};
    else   r = {2'b00, a} * {2'b00, b};
    return r;
  endfunction

  assign bus.dp_out = ref_led(bus.dp_a, bus.dp_b, bus.dp_pb0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Returns the number of negedges until done is seen, or -1 on timeout.
  task automatic wait_done(input int max_cyc, output int lat);
    int k;
    lat = -1;
    k   = 0;
    while (lat < 0 && k < max_cyc) begin
      @(negedge clk);
      k++;
      if (bus.done) lat = k;
    end
  endtask

  task automatic set_sw(input logic [1:0] a, input logic [1:0] b);
    bus.sw_a = a;
    bus.sw_b = b;
    cur_a    = a;
    cur_b    = b;
  endtask

  // Optional bounce, then held high, then released; counts done pulses throughout.
  task automatic press(input int bounce, input int hold, input int rel,
                       output int ndone, output logic [3:0] last_led);
    ndone    = 0;
    last_led = 4'b0000;
    for (int i = 0; i < bounce + hold + rel; i++) begin
      if (i < bounce)             bus.btn_in = (i % 2 == 0);
      else if (i < bounce + hold) bus.btn_in = 1'b1;
      else                        bus.btn_in = 1'b0;
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        last_led = bus.led;
      end
    end
  endtask

  // Press in IDLE: exactly one capture of the unchanged switches with the new mode.
  task automatic toggle_mode(input string name);
    int nd;
    logic [3:0] ll;
    press(0, 40, 40, nd, ll);
    cur_mode = ~cur_mode;
    check({name, "_ndone"}, nd, 1);
    check({name, "_led"}, ll, ref_led(cur_a, cur_b, cur_mode));
    check({name, "_pb0"}, bus.dp_pb0, cur_mode);
  endtask

  // Manual operand change from IDLE: result and latency.
  task automatic manual_step(input string name, input logic [1:0] a, input logic [1:0] b,
                             input logic [3:0] exp_led);
    int lat;
    set_sw(a, b);
    wait_done(30, lat);
    check({name, "_lat"}, lat, LAT);
    check({name, "_led"}, bus.led, exp_led);
    @(negedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic       mode;
    logic [3:0] exp_led;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int lat;
    int nd;
    logic [3:0] ll;
    logic [3:0] idx;
    logic [1:0] ra;
    logic [1:0] rb;
    int exp_done;
    logic [3:0] exp_l;

    n_checks = 0;
    n_err    = 0;
    cur_mode = 1'b0;

    vecs[0] = '{2'd2, 2'd3, 1'b0, 4'b0110};
    vecs[1] = '{2'd1, 2'd1, 1'b0, 4'b0001};
    vecs[2] = '{2'd3, 2'd3, 1'b0, 4'b1001};
    vecs[3] = '{2'd0, 2'd3, 1'b0, 4'b0000};
    vecs[4] = '{2'd2, 2'd1, 1'b1, 4'b0100};
    vecs[5] = '{2'd1, 2'd2, 1'b1, 4'b0001};
    vecs[6] = '{2'd2, 2'd2, 1'b1, 4'b0010};
    vecs[7] = '{2'd0, 2'd0, 1'b1, 4'b0010};
    vecs[8] = '{2'd3, 2'd2, 1'b0, 4'b0110};

    // Reset state
    rst_n       = 1'b0;
    bus.btn_in  = 1'b0;
    bus.auto_en = 1'b0;
    set_sw(2'b01, 2'b11);
    repeat (3) @(negedge clk);
    check("rst_dp_a", bus.dp_a, 0);
    check("rst_dp_b", bus.dp_b, 0);
    check("rst_pb0", bus.dp_pb0, 0);
    check("rst_led", bus.led, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);

    // First capture after reset release, then quiet IDLE
    rst_n = 1'b1;
    wait_done(30, lat);
    check("first_lat", lat, LAT);
    check("first_led", bus.led, 4'b0011);
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    check("idle_no_done", nd, 0);
    check("idle_busy", bus.busy, 0);

    // 11/11: latency and busy window
    set_sw(2'b11, 2'b11);
    check("t3_busy0", bus.busy, 0);
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      check("t3_busy", bus.busy, (k <= LAT) ? 1 : 0);
      check("t3_done", bus.done, (k == LAT) ? 1 : 0);
      if (k == LAT) check("t3_led", bus.led, 4'b1001);
    end
    @(negedge clk);

    // 11/01 in mode 0, then bouncy press toggles mode once
    manual_step("t4_pre", 2'b11, 2'b01, 4'b0011);
    press(5, 40, 40, nd, ll);
    cur_mode = ~cur_mode;
    check("bounce_ndone", nd, 1);
    check("bounce_led", ll, 4'b0100);
    check("bounce_pb0", bus.dp_pb0, 1);

    // Glitch one cycle short of the debounce window
    press(0, DB - 1, 60, nd, ll);
    check("glitch_ndone", nd, 0);
    check("glitch_pb0", bus.dp_pb0, cur_mode);

    // Table-driven vectors
    foreach (vecs[i]) begin
      if (vecs[i].mode != cur_mode) toggle_mode("tbl_tog");
      manual_step("tbl", vecs[i].a, vecs[i].b, vecs[i].exp_led);
      check("tbl_pb0", bus.dp_pb0, vecs[i].mode);
    end

    // Randomized manual operation against the reference model
    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(0, 3) == 0) toggle_mode("rnd_tog");
      do begin
        ra = 2'($urandom_range(0, 3));
        rb = 2'($urandom_range(0, 3));
      end while (ra == cur_a && rb == cur_b);
      manual_step("rnd", ra, rb, ref_led(ra, rb, cur_mode));
    end

    // Auto scan in mode 0: 16 steps plus wrap
    if (cur_mode) toggle_mode("auto_tog");
    bus.auto_en = 1'b1;
    idx = 4'd0;
    for (int p = 0; p < 17; p++) begin
      wait_done(PER + 10, lat);
      check("auto_gap", lat, (p == 0) ? LAT : PER);
      check("auto_led", bus.led, ref_led(idx[3:2], idx[1:0], 1'b0));
      idx = idx + 4'd1;
    end

    // Press timed so the toggle lands in the SETTLE of the step after next:
    // that step restarts in mode 1 and its aborted capture never shows.
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      exp_done = (i == PER) || (i == 2 * PER + 2) || (i == 3 * PER + 2) ||
                 (i == 4 * PER + 2);
      check("abort_done", bus.done, exp_done);
      if (i == PER) begin
        exp_l = ref_led(idx[3:2], idx[1:0], 1'b0);
        check("abort_led0", bus.led, exp_l);
        idx = idx + 4'd1;
      end else if (exp_done != 0) begin
        exp_l = ref_led(idx[3:2], idx[1:0], 1'b1);
        check("abort_led1", bus.led, exp_l);
        idx = idx + 4'd1;
      end
      if (i == 4)  bus.btn_in = 1'b1;
      if (i == 34) bus.btn_in = 1'b0;
    end
    cur_mode = 1'b1;
    check("abort_pb0", bus.dp_pb0, 1);

    // Reset in SETTLE, then the pending capture after release
    bus.auto_en = 1'b0;
    repeat (30) @(negedge clk);
    set_sw(cur_a ^ 2'b01, cur_b);
    @(negedge clk);
    @(negedge clk);
    check("rs_busy_pre", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("rs_dp_a", bus.dp_a, 0);
    check("rs_dp_b", bus.dp_b, 0);
    check("rs_pb0", bus.dp_pb0, 0);
    check("rs_led", bus.led, 0);
    check("rs_busy", bus.busy, 0);
    check("rs_done", bus.done, 0);
    repeat (3) @(negedge clk);
    rst_n    = 1'b1;
    cur_mode = 1'b0;
    wait_done(30, lat);
    check("rs_lat", lat, LAT);
    check("rs_cap_led", bus.led, ref_led(cur_a, cur_b, 1'b0));
    check("rs_cap_pb0", bus.dp_pb0, 0);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
